// File: rtl/video_fade_ctrl.sv
// Frame-rate alpha sequencer: steps alpha_o one level per (rate+1) vsync ticks toward a commanded target.
// Optional ping-pong looping is compiled in with `define VIDEO_FADE_LOOP_EN.
module video_fade_ctrl #(
   parameter int unsigned RATE_W  = 8,
   parameter int unsigned LEVEL_W = 3
) (
   input  logic               clk,
   input  logic               reset_i,
   input  logic               vsync_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [LEVEL_W-1:0] cmd_target_i,
   input  logic [RATE_W-1:0]  cmd_rate_i,
   input  logic               cmd_loop_i,
   input  logic               abort_i,
   output logic [LEVEL_W-1:0] alpha_o,
   output logic               busy_o,
   output logic               done_o
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic                 vsync_1;
   logic                 tick;
   logic [LEVEL_W-1:0]   alpha_q, alpha_d, target_q, target_d, alpha_step;
   logic [RATE_W-1:0]    rate_q, rate_d, cnt_q, cnt_d;
   logic                 busy_q, busy_d, done_q, done_d;
`ifdef VIDEO_FADE_LOOP_EN
   logic                 loop_q, loop_d;
   logic [LEVEL_W-1:0]   start_q, start_d;
`else
   logic                 unused_loop;
   assign unused_loop = cmd_loop_i;
`endif

   assign tick        = vsync_i & ~vsync_1;
   assign cmd_ready_o = (state_q == IDLE) & ~abort_i;
   assign alpha_step  = (target_q > alpha_q) ? alpha_q + LEVEL_W'(1) : alpha_q - LEVEL_W'(1);
   assign alpha_o     = alpha_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

   always_comb begin
      state_d  = state_q;
      alpha_d  = alpha_q;
      target_d = target_q;
      rate_d   = rate_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef VIDEO_FADE_LOOP_EN
      loop_d   = loop_q;
      start_d  = start_q;
`endif
      // abort outranks both a same-cycle tick and a same-cycle command
      if (abort_i) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  target_d = cmd_target_i;
                  rate_d   = cmd_rate_i;
                  cnt_d    = cmd_rate_i;
`ifdef VIDEO_FADE_LOOP_EN
                  loop_d   = cmd_loop_i;
                  start_d  = alpha_q;
`endif
                  if (cmd_target_i == alpha_q) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = RUN;
                     busy_d  = 1'b1;
                  end
               end
            end
            RUN: begin
               if (tick) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - RATE_W'(1);
                  end else begin
                     alpha_d = alpha_step;
                     cnt_d   = rate_q;
                     if (alpha_step == target_q) begin
                        done_d = 1'b1;
`ifdef VIDEO_FADE_LOOP_EN
                        if (loop_q) begin
                           target_d = start_q;
                           start_d  = target_q;
                        end else begin
                           state_d = IDLE;
                           busy_d  = 1'b0;
                        end
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
`endif
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q  <= IDLE;
         vsync_1  <= 1'b0;
         alpha_q  <= '0;
         target_q <= '0;
         rate_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef VIDEO_FADE_LOOP_EN
         loop_q   <= 1'b0;
         start_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         vsync_1  <= vsync_i;
         alpha_q  <= alpha_d;
         target_q <= target_d;
         rate_q   <= rate_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef VIDEO_FADE_LOOP_EN
         loop_q   <= loop_d;
         start_q  <= start_d;
`endif
      end
   end

endmodule

// File: tb/tb_video_fade_ctrl.sv
// Table-driven bench for video_fade_ctrl; expected outputs go through a scoreboard queue.
module tb_video_fade_ctrl;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       vsync_i = 1'b0;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [2:0] cmd_target_i = '0;
   logic [7:0] cmd_rate_i = '0;
   logic       cmd_loop_i = 1'b0;
   logic       abort_i = 1'b0;
   logic [2:0] alpha_o;
   logic       busy_o;
   logic       done_o;

   video_fade_ctrl #(.RATE_W(8), .LEVEL_W(3)) dut (
      .clk(clk), .reset_i(reset_i), .vsync_i(vsync_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_target_i(cmd_target_i), .cmd_rate_i(cmd_rate_i), .cmd_loop_i(cmd_loop_i),
      .abort_i(abort_i), .alpha_o(alpha_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic       rst, vs, valid;
      logic [2:0] tgt;
      logic [7:0] rate;
      logic       loop, abort;
      logic       ready;
      logic [2:0] alpha;
      logic       busy, done;
   } vec_t;

   typedef struct {
      logic [2:0] alpha;
      logic       busy, done;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void v(string tag, logic rst, logic vs, logic valid, logic [2:0] tgt,
                             logic [7:0] rate, logic loop, logic abort, logic ready,
                             logic [2:0] alpha, logic busy, logic done);
      vec_t e;
      e.tag = tag; e.rst = rst; e.vs = vs; e.valid = valid; e.tgt = tgt; e.rate = rate;
      e.loop = loop; e.abort = abort; e.ready = ready; e.alpha = alpha; e.busy = busy; e.done = done;
      vecs.push_back(e);
   endfunction

   // one frame: vsync high for a cycle, then low; outputs are expected to hold in the low cycle
   function automatic void tk(string tag, logic ready_pre, logic [2:0] alpha, logic busy, logic done);
      v(tag, 0, 1, 0, 0, 0, 0, 0, ready_pre, alpha, busy, done);
      v(tag, 0, 0, 0, 0, 0, 0, 0, ~busy, alpha, busy, 1'b0);
   endfunction

   function automatic void cmd(string tag, logic [2:0] tgt, logic [7:0] rate, logic loop,
                               logic [2:0] alpha, logic busy, logic done);
      v(tag, 0, 0, 1, tgt, rate, loop, 0, 1, alpha, busy, done);
   endfunction

   task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      exp_t e;

      // reset state and idle frames
      v("reset", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tk("idle", 1, 0, 0, 0);

      // 0 -> 7 at one level per frame
      cmd("up7_cmd", 7, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 7; k++) tk("up7", 0, 3'(k), k < 7, k == 7);

      // 7 -> 4 stepping every third frame
      cmd("dn4_cmd", 4, 2, 0, 7, 1, 0);
      for (int t = 1; t <= 9; t++) tk("dn4", 0, 3'(7 - t / 3), t < 9, t == 9);

      // down to the 0 endpoint
      cmd("dn0_cmd", 0, 0, 0, 4, 1, 0);
      for (int k = 1; k <= 4; k++) tk("dn0", 0, 3'(4 - k), k < 4, k == 4);

      // abort on the third tick, with a command offered in the same cycle
      cmd("ab_cmd", 7, 0, 0, 0, 1, 0);
      tk("ab_run", 0, 1, 1, 0);
      tk("ab_run", 0, 2, 1, 0);
      v("ab_abort", 0, 1, 1, 5, 0, 0, 1, 0, 2, 0, 0);
      v("ab_accept", 0, 0, 1, 5, 0, 0, 0, 1, 2, 1, 0);
      for (int k = 3; k <= 5; k++) tk("ab_fin", 0, 3'(k), k < 5, k == 5);

      // target equal to current level: immediate done, never busy
      cmd("same_cmd", 5, 0, 0, 5, 0, 1);
      v("same_after", 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      tk("same_idle", 1, 5, 0, 0);

      // vsync held high for 10 cycles gives one tick
      cmd("hold_cmd", 7, 0, 0, 5, 1, 0);
      for (int i = 0; i < 10; i++) v("hold_hi", 0, 1, 0, 0, 0, 0, 0, 0, 6, 1, 0);
      v("hold_lo", 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0);
      tk("hold_fin", 0, 7, 0, 1);

`ifdef VIDEO_FADE_LOOP_EN
      cmd("lp_pre", 2, 0, 0, 7, 1, 0);
      for (int k = 1; k <= 5; k++) tk("lp_pre", 0, 3'(7 - k), k < 5, k == 5);
      cmd("lp_cmd", 5, 0, 1, 2, 1, 0);
      tk("lp", 0, 3, 1, 0);
      tk("lp", 0, 4, 1, 0);
      tk("lp", 0, 5, 1, 1);
      tk("lp", 0, 4, 1, 0);
      tk("lp", 0, 3, 1, 0);
      tk("lp", 0, 2, 1, 1);
      tk("lp", 0, 3, 1, 0);
      tk("lp", 0, 4, 1, 0);
      v("lp_abort", 0, 1, 0, 0, 0, 0, 1, 0, 4, 0, 0);
      v("lp_held", 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
      tk("lp_idle", 1, 4, 0, 0);
`else
      // loop request has no effect in this build
      cmd("noloop_cmd", 4, 0, 1, 7, 1, 0);
      tk("noloop", 0, 6, 1, 0);
      tk("noloop", 0, 5, 1, 0);
      tk("noloop", 0, 4, 0, 1);
      tk("noloop_idle", 1, 4, 0, 0);
`endif

      // reset mid-fade with vsync high across release
      cmd("rst_cmd", 0, 0, 0, 4, 1, 0);
      tk("rst_run", 0, 3, 1, 0);
      v("rst_mid", 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      v("rst_rel", 0, 1, 1, 3, 0, 0, 0, 1, 0, 1, 0);
      v("rst_hold", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      v("rst_lo", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 3; k++) tk("rst_fade", 0, 3'(k), k < 3, k == 3);

      // initial reset before the table takes over
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         reset_i      = vecs[i].rst;
         vsync_i      = vecs[i].vs;
         cmd_valid_i  = vecs[i].valid;
         cmd_target_i = vecs[i].tgt;
         cmd_rate_i   = vecs[i].rate;
         cmd_loop_i   = vecs[i].loop;
         abort_i      = vecs[i].abort;
         #1;
         chk({vecs[i].tag, ".ready"}, i, 8'(cmd_ready_o), 8'(vecs[i].ready));
         e.alpha = vecs[i].alpha;
         e.busy  = vecs[i].busy;
         e.done  = vecs[i].done;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk({vecs[i].tag, ".alpha"}, i, 8'(alpha_o), 8'(e.alpha));
         chk({vecs[i].tag, ".busy"}, i, 8'(busy_o), 8'(e.busy));
         chk({vecs[i].tag, ".done"}, i, 8'(done_o), 8'(e.done));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
